mdu_hilo_unit: RTL and testbench
================================

Name: mdu_hilo_unit

Overview:
- Multiply/HI-LO execution unit that consumes alu_sel_t codes from alu_pkg.
- Executes C_MULT (2) and C_MUL_U (3) as an iterative shift-add multiply into the HI/LO register pair.
- Serves C_MFHI (12) and C_MFLO (13) reads.
- Sits beside the single-cycle ALU in the execute stage; the control path stalls issue on in_ready.

Parameters:
- WIDTH, 32, operand, HI and LO width in bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  op presented
- in_ready  out  1  unit can accept; high only in IDLE
- alu_sel  in  5  alu_pkg::alu_sel_t operation code
- op_a  in  WIDTH  multiplicand (rs)
- op_b  in  WIDTH  multiplier (rt)
- out_valid  out  1  one-cycle pulse: out_data holds an MFHI/MFLO result
- out_data  out  WIDTH  read result; holds its last value when out_valid is low
- mul_done  out  1  one-cycle pulse: HI/LO written this cycle
- busy  out  1  multiply in progress (state is MUL or DONE)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, HI=0, LO=0, out_data=0, out_valid=0, mul_done=0, busy=0. in_ready=1 in the first cycle after rst falls.
- Reset mid-operation aborts the multiply; HI/LO go to 0 and no mul_done is issued.
- Accept condition: in_valid && in_ready, called cycle 0.
- States and transitions:
  - IDLE -> MUL on accept of code 2 or 3.
  - MUL -> DONE after the last iteration.
  - DONE -> IDLE unconditionally.
- MUL_U:
  - Latch A=op_a, B=op_b; clear the 2*WIDTH accumulator.
  - Each MUL cycle: if B[0], add A to the upper WIDTH+1 bits; shift accumulator and B right by 1.
  - Exactly WIDTH iterations, in cycles 1..WIDTH.
- MULT:
  - Latch magnitudes |op_a| and |op_b| as unsigned WIDTH values; 2^(WIDTH-1) is legal.
  - Record neg = op_a[MSB] ^ op_b[MSB].
  - Run the same iteration as MUL_U.
  - In DONE, two's-complement negate the full 2*WIDTH product if neg.
- DONE (cycle WIDTH+1):
  - mul_done=1.
  - {HI,LO} <= product at the end of the cycle.
  - in_ready returns to 1 in cycle WIDTH+2, so back-to-back multiplies start WIDTH+2 cycles apart.
- MFHI / MFLO:
  - Accepted only in IDLE.
  - Cycle 1: out_valid=1, out_data=HI or LO respectively; no state change.
  - A read accepted in the cycle right after DONE returns the new value.
- Interlock: while busy, in_ready=0. The requester must hold in_valid/alu_sel/operands until accepted.
- All other codes (0,1,4-11,14) and undefined codes 15-31:
  - Accepted in IDLE.
  - No effect on HI/LO and no out_valid (ALU-owned ops).
- in_valid while in_ready=0 is ignored; nothing is queued.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - In MUL, if the remaining B == 0, go to DONE instead of iterating further.
  - In DONE, the accumulator is right-shifted by the number of skipped iterations before sign fix and write.
  - An iteration count of k gives DONE in cycle k+1, where k = position of the highest set bit of |op_b| + 1.
  - |op_b|=0 gives DONE in cycle 1.
  - Results are bit-identical to the non-early-terminated result.
- Undefined: fixed WIDTH iterations; no barrel shift is synthesized.

Test Plan:
1. MUL_U 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32) -> mul_done in cycle 33, HI=0xFFFFFFFE, LO=0x00000001; a following MFHI gives out_valid with 0xFFFFFFFE one cycle after accept.
2. MULT 0xFFFFFFFD(-3)*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
3. MFLO held on in_valid during a multiply -> in_ready=0 through cycle 33; accepted in cycle 34; out_valid in cycle 35 carries the new LO.
4. rst pulsed during iteration 10 of MUL_U 6*7 -> no mul_done; next MFHI and MFLO both return 0; in_ready=1 the cycle after rst falls.
5. codes 0 (C_ADD_U), 14 (C_JR) and 20 with HI=5 -> each accepted in 1 cycle, out_valid stays 0, MFHI still returns 5.
6. MDU_EARLY_TERM_EN defined: MUL_U 7*3 -> mul_done in cycle 3, HI=0, LO=21; MUL_U 9*0 -> mul_done in cycle 1, LO=0. Macro undefined: both finish in cycle 33.

Source files
------------

// File: rtl/mdu_hilo_unit.sv
// Iterative shift-add multiply unit with HI/LO register pair and MFHI/MFLO reads.
// Optional macro MDU_EARLY_TERM_EN stops iterating once the remaining multiplier is zero.
module mdu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             mul_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] C_MULT  = 5'd2;
  localparam logic [4:0] C_MUL_U = 5'd3;
  localparam logic [4:0] C_MFHI  = 5'd12;
  localparam logic [4:0] C_MFLO  = 5'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               is_mul, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   b_step;
  logic               last_iter;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fixed;
`ifdef MDU_EARLY_TERM_EN
  logic [CW-1:0]      shift_amt;
`endif

  // Operand conditioning and one shift-add step of the multiply datapath.
  always_comb begin
    is_signed = (alu_sel == C_MULT);
    is_mul    = (alu_sel == C_MULT) || (alu_sel == C_MUL_U);
    mag_a     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    acc_step = {sum, acc[WIDTH-1:1]};
    b_step   = b_reg >> 1;

`ifdef MDU_EARLY_TERM_EN
    last_iter = (cnt == CW'(WIDTH - 1)) || (b_step == '0);
    // Skipped iterations would only have shifted right, so apply them at once.
    shift_amt = CW'(WIDTH) - cnt;
    product   = acc >> shift_amt;
`else
    last_iter = (cnt == CW'(WIDTH - 1));
    product   = acc;
`endif
    product_fixed = neg ? -product : product;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == S_IDLE);
    busy       = (state == S_MUL) || (state == S_DONE);
    mul_done   = (state == S_DONE);
    accept     = in_valid && in_ready;

    case (state)
      S_IDLE: begin
        if (accept && is_mul) begin
`ifdef MDU_EARLY_TERM_EN
          state_next = (mag_b == '0) ? S_DONE : S_MUL;
`else
          state_next = S_MUL;
`endif
        end
      end
      S_MUL: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, iteration, HI/LO write-back and register reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              a_reg <= mag_a;
              b_reg <= mag_b;
              acc   <= '0;
              cnt   <= '0;
              neg   <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            end else if (alu_sel == C_MFHI) begin
              out_valid <= 1'b1;
              out_data  <= hi;
            end else if (alu_sel == C_MFLO) begin
              out_valid <= 1'b1;
              out_data  <= lo;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_step;
          b_reg <= b_step;
          cnt   <= cnt + CW'(1);
        end
        S_DONE: begin
          hi <= product_fixed[2*WIDTH-1:WIDTH];
          lo <= product_fixed[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed test-plan steps plus random multiplies
// checked against a plain-arithmetic product/latency model.
module tb_mdu_hilo_unit;

  localparam int W = 32;

  localparam logic [4:0] C_ADD_U = 5'd0;
  localparam logic [4:0] C_MULT  = 5'd2;
  localparam logic [4:0] C_MUL_U = 5'd3;
  localparam logic [4:0] C_MFHI  = 5'd12;
  localparam logic [4:0] C_MFLO  = 5'd13;
  localparam logic [4:0] C_JR    = 5'd14;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   alu_sel;
  logic [W-1:0] op_a, op_b;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         mul_done;
  logic         busy;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_sel  (alu_sel),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_data (out_data),
    .mul_done (mul_done),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Full 64-bit product from ordinary integer arithmetic.
  function automatic logic [63:0] refProduct(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sel == C_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Cycle (counted from accept = cycle 0) in which mul_done is expected.
  function automatic int expDoneCycle(input logic [4:0] sel, input logic [W-1:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0] mag;
    int k;
    mag = (sel == C_MULT && b[W-1]) ? -b : b;
    k = 0;
    for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
    return k + 1;
`else
    return W + 1;
`endif
  endfunction

  // Presents an op at a falling edge; the following rising edge is cycle 0's end.
  task automatic applyStimulus(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_sel  = sel;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic readReg(input string tag, input logic [4:0] sel, input logic [W-1:0] expected);
    applyStimulus(sel, '0, '0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " out_data"}, 64'(out_data), 64'(expected));
  endtask

  task automatic runMul(input string tag, input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int done_cyc;
    logic [63:0] p;
    cyc = 0;
    done_cyc = -1;
    checkOutput({tag, " ready at issue"}, 64'(in_ready), 64'd1);
    applyStimulus(sel, a, b);
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (mul_done === 1'b1) done_cyc = cyc;
    end
    checkOutput({tag, " done cycle"}, 64'(done_cyc), 64'(expDoneCycle(sel, b)));
    p = refProduct(sel, a, b);
    model_hi = p[63:32];
    model_lo = p[31:0];
    @(negedge clk);
    checkOutput({tag, " ready after done"}, 64'(in_ready), 64'd1);
    readReg({tag, " MFHI"}, C_MFHI, model_hi);
    readReg({tag, " MFLO"}, C_MFLO, model_lo);
  endtask

  initial begin
    int d;
    int bad;
    int rst_cyc;
    int done_seen;
    logic [W-1:0] corners [6];
    logic [4:0] rsel;
    logic [W-1:0] ra, rb;

    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h8000_0001;

    rst      = 1'b1;
    in_valid = 1'b0;
    alu_sel  = '0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    checkOutput("reset mul_done", 64'(mul_done), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    readReg("reset", C_MFHI, '0);
    readReg("reset", C_MFLO, '0);

    $display("[TB] step 1: unsigned all-ones");
    runMul("mulu ff*ff", C_MUL_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulu ff*ff hi const", 64'(model_hi), 64'hFFFF_FFFE);
    checkOutput("mulu ff*ff lo const", 64'(model_lo), 64'h0000_0001);

    $display("[TB] step 2: signed");
    runMul("mult -3*5", C_MULT, 32'hFFFF_FFFD, 32'd5);
    readReg("mult -3*5 const hi", C_MFHI, 32'hFFFF_FFFF);
    readReg("mult -3*5 const lo", C_MFLO, 32'hFFFF_FFF1);
    runMul("mult min*min", C_MULT, 32'h8000_0000, 32'h8000_0000);
    readReg("mult min*min const hi", C_MFHI, 32'h4000_0000);

    $display("[TB] step 3: MFLO held through a multiply");
    d = expDoneCycle(C_MUL_U, 32'h0001_2345);
    applyStimulus(C_MUL_U, 32'h1234_5678, 32'h0001_2345);
    bad = 0;
    done_seen = -1;
    for (int cyc = 1; cyc <= d; cyc++) begin
      @(negedge clk);
      alu_sel = C_MFLO;
      if (in_ready !== 1'b0) bad++;
      if (mul_done === 1'b1) done_seen = cyc;
    end
    checkOutput("held mflo ready low while busy", 64'(bad), 64'd0);
    checkOutput("held mflo done cycle", 64'(done_seen), 64'(d));
    model_lo = refProduct(C_MUL_U, 32'h1234_5678, 32'h0001_2345) >> 0;
    model_hi = 32'(refProduct(C_MUL_U, 32'h1234_5678, 32'h0001_2345) >> 32);
    @(negedge clk);
    checkOutput("held mflo accepted", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("held mflo out_valid", 64'(out_valid), 64'd1);
    checkOutput("held mflo out_data", 64'(out_data), 64'(model_lo));

    $display("[TB] step 4: reset mid-multiply");
`ifdef MDU_EARLY_TERM_EN
    rst_cyc = 2;
`else
    rst_cyc = 10;
`endif
    done_seen = 0;
    applyStimulus(C_MUL_U, 32'd6, 32'd7);
    for (int cyc = 1; cyc <= rst_cyc; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (mul_done === 1'b1) done_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst mid-op in_ready", 64'(in_ready), 64'd1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mul_done === 1'b1) done_seen++;
      @(negedge clk);
    end
    checkOutput("rst mid-op no mul_done", 64'(done_seen), 64'd0);
    model_hi = '0;
    model_lo = '0;
    readReg("rst mid-op", C_MFHI, model_hi);
    readReg("rst mid-op", C_MFLO, model_lo);

    $display("[TB] step 5: ALU-owned codes");
    runMul("set hi5", C_MUL_U, 32'h5000_0000, 32'h0000_0010);
    checkOutput("set hi5 const", 64'(model_hi), 64'd5);
    foreach (corners[i]) begin
      if (i < 3) begin
        rsel = (i == 0) ? C_ADD_U : (i == 1) ? C_JR : 5'd20;
        checkOutput($sformatf("code %0d ready", rsel), 64'(in_ready), 64'd1);
        applyStimulus(rsel, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput($sformatf("code %0d no out_valid", rsel), 64'(out_valid), 64'd0);
        checkOutput($sformatf("code %0d one cycle", rsel), 64'(in_ready), 64'd1);
      end
    end
    readReg("after alu codes", C_MFHI, 32'd5);

    $display("[TB] step 6: latency by multiplier width");
    runMul("mulu 7*3", C_MUL_U, 32'd7, 32'd3);
    runMul("mulu 9*0", C_MUL_U, 32'd9, 32'd0);
`ifdef MDU_EARLY_TERM_EN
    checkOutput("early 7*3 latency", 64'(expDoneCycle(C_MUL_U, 32'd3)), 64'd3);
`endif

    $display("[TB] random multiplies");
    for (int n = 0; n < 24; n++) begin
      rsel = ($urandom_range(0, 1) == 0) ? C_MULT : C_MUL_U;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : ($urandom() >> $urandom_range(0, 31));
      runMul($sformatf("rand%0d sel%0d %h*%h", n, rsel, ra, rb), rsel, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
